// File: rtl/mcycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_control_unit
//  Description : Moore-FSM control unit for the multi-cycle ARM processor.
//                Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, holds the
//                NZCV flag register, evaluates condition codes at DECODE and
//                (MCYCLE_EN=1) launches MUL/DIV on the external MCycle unit
//                with a busy-wait timeout that raises a sticky Fault.
//  Ports       : CLK, RESETn (sync, active-low), Instr, ALUFlags, MCycleBusy
//                -> PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
//                   ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl,
//                   MCycleStart, MCycleOp, Flags, Fault
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_control_unit #(
    parameter int MCYCLE_EN = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MCycleBusy,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        MCycleStart,
    output logic        MCycleOp,
    output logic [3:0]  Flags,
    output logic        Fault
);

    localparam int             c_CW    = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TO    = c_CW'(TIMEOUT);
    localparam bit             c_MC_EN = (MCYCLE_EN != 0);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_MCSTART = 4'd10,
        S_MCWAIT  = 4'd11,
        S_MCWB    = 4'd12
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_flags;
    logic              r_fault;
    logic [c_CW-1:0]   r_cnt;

    logic [1:0]        w_op;
    logic [3:0]        w_cmd;
    logic              w_cmp;
    logic              w_mcpat;
    logic              w_cond;
    logic [c_CW-1:0]   w_cnt_inc;
    logic              w_timeout;
    logic [1:0]        w_dp_alu;

    logic w_pcwrite, w_irwrite, w_memwrite, w_regwrite, w_mcstart;

    assign w_op      = Instr[27:26];
    assign w_cmd     = Instr[24:21];
    assign w_cmp     = (w_cmd == 4'b1010) || (w_cmd == 4'b1011);
    assign w_mcpat   = c_MC_EN && (Instr[7:4] == 4'b1001);
    assign w_cnt_inc = r_cnt + 1'b1;
    // Timeout fires on the MCWAIT cycle whose post-increment count hits TIMEOUT.
    assign w_timeout = (w_cnt_inc == c_TO);

    logic w_unused;
    assign w_unused = &{1'b0, Instr[19:8], Instr[3:0]};

    // ARM condition evaluation against the registered NZCV.
    always_comb begin
        w_cond = 1'b1;
        case (Instr[31:28])
            4'b0000: w_cond = r_flags[2];
            4'b0001: w_cond = ~r_flags[2];
            4'b0010: w_cond = r_flags[1];
            4'b0011: w_cond = ~r_flags[1];
            4'b0100: w_cond = r_flags[3];
            4'b0101: w_cond = ~r_flags[3];
            4'b0110: w_cond = r_flags[0];
            4'b0111: w_cond = ~r_flags[0];
            4'b1000: w_cond = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond = r_flags[2] | (r_flags[3] != r_flags[0]);
            default: w_cond = 1'b1;
        endcase
    end

    // Data-processing ALU op; CMP/CMN reuse SUB/ADD, unknown commands add.
    always_comb begin
        w_dp_alu = 2'b00;
        case (w_cmd)
            4'b0100: w_dp_alu = 2'b00;
            4'b0010: w_dp_alu = 2'b01;
            4'b0000: w_dp_alu = 2'b10;
            4'b1100: w_dp_alu = 2'b11;
            4'b1010: w_dp_alu = 2'b01;
            4'b1011: w_dp_alu = 2'b00;
            default: w_dp_alu = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ALUWB && (Instr[20] || w_cmp)) begin
                r_flags <= ALUFlags;
            end
            if (r_state == S_MCSTART) begin
                r_cnt <= '0;
            end else if (r_state == S_MCWAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == S_MCWAIT && MCycleBusy && w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_mcstart   = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ImmSrc      = 2'b00;
        RegSrc      = 2'b00;
        ALUControl  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!w_cond) begin
                    w_next = S_FETCH;
                end else begin
                    case (w_op)
                        2'b01:   w_next = S_MEMADR;
                        2'b10:   w_next = S_BRANCH;
                        2'b00:   w_next = Instr[25] ? S_EXECI :
                                          (w_mcpat ? S_MCSTART : S_EXECR);
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = Instr[23] ? 2'b00 : 2'b01;
                w_next     = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                RegSrc     = 2'b10;
            end
            S_EXECR: begin
                ALUControl = w_dp_alu;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = ~w_cmp;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                RegSrc    = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_MCSTART: begin
                w_mcstart = 1'b1;
                w_next    = S_MCWAIT;
            end
            S_MCWAIT: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (!MCycleBusy) begin
                    w_next = S_MCWB;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MCWAIT;
                end
            end
            S_MCWB: begin
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write enables are held off for as long as reset is low.
    assign PCWrite     = w_pcwrite  & RESETn;
    assign IRWrite     = w_irwrite  & RESETn;
    assign MemWrite    = w_memwrite & RESETn;
    assign RegWrite    = w_regwrite & RESETn;
    assign MCycleStart = w_mcstart  & RESETn;
    assign MCycleOp    = Instr[21];
    assign Flags       = r_flags;
    assign Fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcycle_control_unit
//  Description : Self-checking bench for mcycle_control_unit. Instance 0 has
//                MCYCLE_EN=1, instance 1 has MCYCLE_EN=0; both TIMEOUT=4.
//                A phase-list reference model predicts every cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcycle_control_unit;

    localparam int TO = 4;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MW, P_WR, P_XR, P_XI, P_AW, P_BR,
                  P_MS, P_WT, P_MB} phase_t;

    logic        CLK;
    logic        rstn_v  [2];
    logic [31:0] instr_v [2];
    logic [3:0]  af_v    [2];
    logic        busy_v  [2];
    logic        pcw [2], irw [2], mw [2], rw [2], adr [2], sa [2];
    logic [1:0]  sb [2], rs [2], im [2], rg [2], al [2];
    logic        ms [2], mop [2], flt [2];
    logic [3:0]  flg [2];

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [3:0]  m_flags [2];
    logic        m_fault [2];

    mcycle_control_unit #(.MCYCLE_EN(1), .TIMEOUT(TO)) u_dut (
        .CLK(CLK), .RESETn(rstn_v[0]), .Instr(instr_v[0]), .ALUFlags(af_v[0]),
        .MCycleBusy(busy_v[0]), .PCWrite(pcw[0]), .IRWrite(irw[0]),
        .MemWrite(mw[0]), .RegWrite(rw[0]), .AdrSrc(adr[0]), .ALUSrcA(sa[0]),
        .ALUSrcB(sb[0]), .ResultSrc(rs[0]), .ImmSrc(im[0]), .RegSrc(rg[0]),
        .ALUControl(al[0]), .MCycleStart(ms[0]), .MCycleOp(mop[0]),
        .Flags(flg[0]), .Fault(flt[0]));

    mcycle_control_unit #(.MCYCLE_EN(0), .TIMEOUT(TO)) u_dut0 (
        .CLK(CLK), .RESETn(rstn_v[1]), .Instr(instr_v[1]), .ALUFlags(af_v[1]),
        .MCycleBusy(busy_v[1]), .PCWrite(pcw[1]), .IRWrite(irw[1]),
        .MemWrite(mw[1]), .RegWrite(rw[1]), .AdrSrc(adr[1]), .ALUSrcA(sa[1]),
        .ALUSrcB(sb[1]), .ResultSrc(rs[1]), .ImmSrc(im[1]), .RegSrc(rg[1]),
        .ALUControl(al[1]), .MCycleStart(ms[1]), .MCycleOp(mop[1]),
        .Flags(flg[1]), .Fault(flt[1]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Condition pass: odd codes invert the even-code predicate; 1110 is always.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic bit is_cmp(input logic [3:0] cmd);
        return (cmd == 4'b1010) || (cmd == 4'b1011);
    endfunction

    // Packing: {PCW,IRW,MemW,RegW,AdrSrc,SrcA,SrcB,ResSrc,ImmSrc,RegSrc,ALUCtl,MCStart}
    function automatic logic [16:0] exp_out(input phase_t p, input logic [31:0] ins);
        logic pc = 0, ir = 0, mwr = 0, rwr = 0, ad = 0, a = 0, st = 0;
        logic [1:0] b = 0, r = 0, i = 0, g = 0, c = 0;
        case (p)
            P_F:  begin ir = 1; pc = 1; a = 1; b = 2'b10; r = 2'b10; end
            P_D:  begin a = 1; b = 2'b10; r = 2'b10; end
            P_MA: begin b = 2'b01; i = 2'b01; c = ins[23] ? 2'b00 : 2'b01; end
            P_MR: ad = 1;
            P_MW: begin r = 2'b01; rwr = 1; end
            P_WR: begin ad = 1; mwr = 1; g = 2'b10; end
            P_XR: c = alu_of(ins[24:21]);
            P_XI: begin b = 2'b01; c = alu_of(ins[24:21]); end
            P_AW: rwr = !is_cmp(ins[24:21]);
            P_BR: begin b = 2'b01; i = 2'b10; g = 2'b01; r = 2'b10; pc = 1; end
            P_MS: st = 1;
            P_MB: begin r = 2'b11; rwr = 1; end
            default: ;
        endcase
        return {pc, ir, mwr, rwr, ad, a, b, r, i, g, c, st};
    endfunction

    function automatic logic [16:0] get_obs(input int w);
        return {pcw[w], irw[w], mw[w], rw[w], adr[w], sa[w], sb[w], rs[w],
                im[w], rg[w], al[w], ms[w]};
    endfunction

    function automatic logic [4:0] get_we(input int w);
        return {pcw[w], irw[w], mw[w], rw[w], ms[w]};
    endfunction

    // Runs one instruction on instance w, checking every cycle; abort_at >= 0
    // asserts reset during that phase index instead of completing it.
    task automatic run_instr(input int w, input logic [31:0] ins, input logic [3:0] af,
                             input int busy_n, input int abort_at);
        phase_t ph[$];
        bit     bz[$];
        bit     to = 0;
        bit     en = (w == 0);
        ph.push_back(P_F); ph.push_back(P_D);
        if (cond_ok(ins[31:28], m_flags[w])) begin
            case (ins[27:26])
                2'b01: begin
                    ph.push_back(P_MA);
                    if (ins[20]) begin ph.push_back(P_MR); ph.push_back(P_MW); end
                    else ph.push_back(P_WR);
                end
                2'b10: ph.push_back(P_BR);
                2'b00: begin
                    if (ins[25]) begin ph.push_back(P_XI); ph.push_back(P_AW); end
                    else if (en && ins[7:4] == 4'b1001) ph.push_back(P_MS);
                    else begin ph.push_back(P_XR); ph.push_back(P_AW); end
                end
                default: ;
            endcase
        end
        for (int k = 0; k < ph.size(); k++) bz.push_back(1'($urandom_range(0, 1)));
        if (ph[ph.size()-1] == P_MS) begin
            for (int k = 1; k <= TO; k++) begin
                if (k > busy_n) begin
                    ph.push_back(P_WT); bz.push_back(1'b0);
                    ph.push_back(P_MB); bz.push_back(1'($urandom_range(0, 1)));
                    break;
                end
                ph.push_back(P_WT); bz.push_back(1'b1);
                if (k == TO) to = 1;
            end
        end
        for (int i = 0; i < ph.size(); i++) begin
            instr_v[w] = ins;
            af_v[w]    = af;
            busy_v[w]  = bz[i];
            if (i == abort_at) begin
                rstn_v[w] = 1'b0;
                #2;
                check($sformatf("rst_mid_%s_we", ph[i].name()), 32'(get_we(w)), 32'h0);
                @(posedge CLK); #1;
                check("rst_after_we", 32'(get_we(w)), 32'h0);
                check("rst_after_flags", 32'(flg[w]), 32'h0);
                check("rst_after_fault", 32'(flt[w]), 32'h0);
                m_flags[w] = 4'b0000;
                m_fault[w] = 1'b0;
                rstn_v[w]  = 1'b1;
                #1;
                return;
            end
            #2;
            check($sformatf("i%0d_%s_%08h_out", w, ph[i].name(), ins),
                  32'(get_obs(w)), 32'(exp_out(ph[i], ins)));
            check($sformatf("i%0d_%s_flags", w, ph[i].name()), 32'(flg[w]), 32'(m_flags[w]));
            check($sformatf("i%0d_%s_fault", w, ph[i].name()), 32'(flt[w]), 32'(m_fault[w]));
            if (ph[i] == P_MS || ph[i] == P_WT || ph[i] == P_MB)
                check($sformatf("i%0d_%s_mcop", w, ph[i].name()), 32'(mop[w]), 32'(ins[21]));
            @(posedge CLK); #1;
            if (ph[i] == P_AW && (ins[20] || is_cmp(ins[24:21]))) m_flags[w] = af;
            if (to && i == ph.size() - 1) m_fault[w] = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0]  cmds [6];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b1011;
        ins = $urandom;
        ins[31:28] = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 3) != 0) ins[24:21] = cmds[$urandom_range(0, 5)];
        if ($urandom_range(0, 4) == 0) begin
            ins[27:25] = 3'b000;
            ins[7:4]   = 4'b1001;
        end
        return ins;
    endfunction

    initial begin
        for (int w = 0; w < 2; w++) begin
            rstn_v[w] = 1'b0; instr_v[w] = '0; af_v[w] = '0; busy_v[w] = 1'b0;
            m_flags[w] = 4'b0000; m_fault[w] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #2;
        for (int w = 0; w < 2; w++) begin
            check($sformatf("reset%0d_we", w), 32'(get_we(w)), 32'h0);
            check($sformatf("reset%0d_flags", w), 32'(flg[w]), 32'h0);
            check($sformatf("reset%0d_fault", w), 32'(flt[w]), 32'h0);
        end
        @(posedge CLK); #1;
        rstn_v[0] = 1'b1;

        run_instr(0, 32'hE0900000, 4'b0100, 0, -1);   // ADDS, Z result
        check("adds_flags", 32'(flg[0]), 32'h4);
        run_instr(0, 32'h00800000, 4'b1111, 0, -1);   // ADDEQ executes
        run_instr(0, 32'h10800000, 4'b1111, 0, -1);   // ADDNE skipped
        run_instr(0, 32'hE1500000, 4'b1000, 0, -1);   // CMP
        check("cmp_flags", 32'(flg[0]), 32'h8);
        run_instr(0, 32'hE4100000, 4'b0000, 0, -1);   // LDR, U=0
        run_instr(0, 32'hE4800000, 4'b0000, 0, -1);   // STR, U=1
        run_instr(0, 32'hEA000000, 4'b0000, 0, -1);   // B
        run_instr(0, 32'hE0000090, 4'b0000, 3, -1);   // MUL, 3 busy cycles
        run_instr(0, 32'hE0200090, 4'b0000, 100, -1); // DIV, stuck busy
        check("div_timeout_fault", 32'(flt[0]), 32'h1);

        for (int n = 0; n < 150; n++)
            run_instr(0, rand_instr(), 4'($urandom), $urandom_range(0, 5), -1);

        run_instr(0, 32'hE0200090, 4'b0000, 100, -1); // ensure Fault set
        run_instr(0, 32'hE0900000, 4'b1010, 0, -1);   // nonzero flags
        run_instr(0, 32'hE4800000, 4'b0000, 0, 3);    // reset during MEMWR
        run_instr(0, 32'hE0900000, 4'b0001, 0, -1);

        rstn_v[1] = 1'b1;
        run_instr(1, 32'hE0300090, 4'b0110, 100, -1); // DIVS pattern as ADD
        check("en0_flags", 32'(flg[1]), 32'h6);
        run_instr(1, 32'hE0000090, 4'b0000, 100, -1);
        for (int n = 0; n < 20; n++)
            run_instr(1, rand_instr(), 4'($urandom), $urandom_range(0, 5), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
